cordic_sqrt_responder: RTL

- Responder end of the square-root request/response handshake: takes a 32-bit unsigned radicand with a valid strobe and returns a 24-bit root with a one-cycle valid pulse.
- Fixed-point root in Q16.8, computed by an iterative restoring digit-by-digit algorithm, one result bit per clock.
- Sits opposite the magnitude/accumulate controller. Drop-in for the vendor CORDIC square-root core on that link.

---
 rtl/cordic_pkg.sv | 22 ++
 rtl/sqrt_step.sv | 39 +++
 rtl/cordic_sqrt_responder.sv | 133 +++++++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
// Shared types and constants for the square-root responder on the CORDIC link.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package cordic_pkg;

  localparam int RADICAND_W = 32;
  localparam int ROOT_W     = 24;
  // One root bit is resolved per iteration.
  localparam int ITER_N     = ROOT_W;
  // Remainder never exceeds 2*root, so two guard bits above the root suffice.
  localparam int REM_W      = ROOT_W + 2;
  localparam int EXT_W      = 2 * ROOT_W;
  localparam int CNT_W      = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SKEW = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/sqrt_step.sv
// One restoring digit-by-digit square-root iteration (pure combinational).
// Latency: 0 cycles.
// Backpressure: none; the caller registers the outputs.
module sqrt_step
  import cordic_pkg::*;
(
  input  logic [REM_W-1:0]  rem,
  input  logic [ROOT_W-1:0] root,
  input  logic [1:0]        pair,
  output logic [REM_W-1:0]  rem_nxt,
  output logic [ROOT_W-1:0] root_nxt
);

  logic [REM_W-1:0] rem_sh;
  logic [REM_W-1:0] sub;
  logic [REM_W:0]   trial;
  logic             neg;
  // The dropped top bits are always zero while an iteration is in flight:
  // the remainder stays below 2^24 before its final shift and the root has
  // fewer than ROOT_W significant bits until the last step.
  logic             unused_top;

  assign rem_sh     = {rem[REM_W-3:0], pair};
  assign sub        = {root, 2'b01};
  assign trial      = {1'b0, rem_sh} - {1'b0, sub};
  assign neg        = trial[REM_W];
  assign unused_top = ^{rem[REM_W-1:REM_W-2], root[ROOT_W-1]};

  // Keep the trial difference only when it did not borrow; that bit becomes the new root digit.
  always_comb begin
    rem_nxt  = rem_sh;
    root_nxt = {root[ROOT_W-2:0], 1'b0};
    if (!neg) begin
      rem_nxt  = trial[REM_W-1:0];
      root_nxt = {root[ROOT_W-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/cordic_sqrt_responder.sv
// Square-root responder: 32-bit unsigned radicand in, Q16.8 root out with a one-cycle valid pulse.
// Latency: IN_SKEW+25 cycles from the request edge to the result pulse; 24 iterations, one bit per clock.
// Backpressure: none; request edges seen while busy are dropped, and a held valid never retriggers.
module cordic_sqrt_responder
  import cordic_pkg::*;
#(
  // Fractional root bits; must stay 8 so the root is 24 bits wide on this link.
  parameter int FRAC_BITS = 8,
  // Cycles between the request edge and the radicand being valid (0 or 1).
  parameter int IN_SKEW   = 1
)
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  CORDIC_Valid_in,
  input  logic [RADICAND_W-1:0] CORDIC_out,
  output logic [ROOT_W-1:0]     CORDIC_in,
  output logic                  CORDIC_Valid_out,
  output logic                  busy
);

  state_t             state_q;
  state_t             state_d;
  logic               valid_d_q;
  logic               req_edge;
  logic               capture;
  logic [EXT_W-1:0]   rad_q;
  logic [REM_W-1:0]   rem_q;
  logic [ROOT_W-1:0]  root_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [REM_W-1:0]   rem_nxt;
  logic [ROOT_W-1:0]  root_nxt;
  logic               last_iter;

  // Clears to 0 so a valid already high when reset lifts is treated as a fresh edge.
  assign req_edge  = CORDIC_Valid_in && !valid_d_q;
  assign last_iter = (state_q == CALC) && (cnt_q == '0);

  sqrt_step u_step (
    .rem      (rem_q),
    .root     (root_q),
    .pair     (rad_q[EXT_W-1 -: 2]),
    .rem_nxt  (rem_nxt),
    .root_nxt (root_nxt)
  );

  // Remember last cycle's valid level for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_d_q <= 1'b0;
    end else begin
      valid_d_q <= CORDIC_Valid_in;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; capture marks the cycle whose radicand is loaded.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_edge) begin
          if (IN_SKEW == 0) begin
            capture = 1'b1;
            state_d = CALC;
          end else begin
            state_d = SKEW;
          end
        end
      end
      SKEW: begin
        capture = 1'b1;
        state_d = CALC;
      end
      CALC: begin
        if (cnt_q == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Iteration datapath: load on capture, then consume two radicand bits per CALC cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rad_q  <= '0;
      rem_q  <= '0;
      root_q <= '0;
      cnt_q  <= '0;
    end else if (capture) begin
      rad_q  <= {CORDIC_out, {(2*FRAC_BITS){1'b0}}};
      rem_q  <= '0;
      root_q <= '0;
      cnt_q  <= CNT_W'(ITER_N - 1);
    end else if (state_q == CALC) begin
      rad_q  <= {rad_q[EXT_W-3:0], 2'b00};
      rem_q  <= rem_nxt;
      root_q <= root_nxt;
      cnt_q  <= cnt_q - 1'b1;
    end
  end

  // Registered outputs: result and pulse land together in DONE; busy follows the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      CORDIC_in        <= '0;
      CORDIC_Valid_out <= 1'b0;
      busy             <= 1'b0;
    end else begin
      CORDIC_Valid_out <= last_iter;
      busy             <= (state_d != IDLE);
      if (last_iter) begin
        CORDIC_in <= root_nxt;
      end
    end
  end

endmodule
